// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use interlock, branch squash,
// and sequencing of the multi-cycle mul/div unit that sits in X.
module pipe_hazard_ctrl #(
  parameter int unsigned MD_TIMEOUT  = 40,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   ctrl_reset_n,
  input  logic [4:0]             fd_opcode,
  input  logic [4:0]             fd_rs,
  input  logic [4:0]             fd_rt,
  input  logic [4:0]             dx_opcode,
  input  logic [4:0]             dx_alu,
  input  logic [4:0]             dx_rd,
  input  logic                   branch_taken,
  input  logic                   md_ready,
  output logic                   pc_we,
  output logic                   fd_we,
  output logic                   fd_flush,
  output logic                   dx_we,
  output logic                   dx_flush,
  output logic                   xm_bubble,
  output logic                   md_start,
  output logic                   md_busy,
  output logic                   md_timeout,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam int unsigned CNT_W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] MD_LAST = CNT_W'(MD_TIMEOUT - 1);

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic is_md;
    logic is_lw;
    logic rs_used;
    logic rt_used;
  } decode_t;

  state_t     state, state_nxt;
  logic [CNT_W-1:0] md_cnt, md_cnt_nxt;
  logic       timeout_hit;
  decode_t    dec;
  logic       load_use;

  always_comb begin
    dec.is_md   = (dx_opcode == OP_RTYPE) && ((dx_alu == ALU_MUL) || (dx_alu == ALU_DIV));
    dec.is_lw   = (dx_opcode == OP_LW);
    dec.rs_used = !((fd_opcode == OP_J) || (fd_opcode == OP_JAL) || (fd_opcode == OP_SETX));
    dec.rt_used = (fd_opcode == OP_RTYPE) || (fd_opcode == OP_BNE) || (fd_opcode == OP_BLT) ||
                  (fd_opcode == OP_SW)    || (fd_opcode == OP_JR);
  end

  // Register 0 is hardwired zero, so a load targeting it can never create a dependency.
  assign load_use = dec.is_lw && (dx_rd != 5'd0) &&
                    ((dec.rs_used && (fd_rs == dx_rd)) || (dec.rt_used && (fd_rt == dx_rd)));

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    pc_we       = 1'b1;
    fd_we       = 1'b1;
    dx_we       = 1'b1;
    fd_flush    = 1'b0;
    dx_flush    = 1'b0;
    xm_bubble   = 1'b0;
    md_start    = 1'b0;
    md_busy     = 1'b0;
    timeout_hit = 1'b0;
    state_nxt   = state;
    md_cnt_nxt  = md_cnt;

    if (!ctrl_reset_n) begin
      pc_we     = 1'b0;
      fd_we     = 1'b0;
      dx_we     = 1'b0;
      fd_flush  = 1'b1;
      dx_flush  = 1'b1;
      state_nxt = IDLE;
      md_cnt_nxt = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (branch_taken) begin
            fd_flush = 1'b1;
            dx_flush = 1'b1;
          end else if (dec.is_md) begin
            md_start   = 1'b1;
            pc_we      = 1'b0;
            fd_we      = 1'b0;
            dx_we      = 1'b0;
            xm_bubble  = 1'b1;
            state_nxt  = BUSY;
            md_cnt_nxt = '0;
          end else if (load_use) begin
            pc_we    = 1'b0;
            fd_we    = 1'b0;
            dx_flush = 1'b1;
          end
        end
        BUSY: begin
          md_busy = 1'b1;
          if (md_ready || (md_cnt == MD_LAST)) begin
            // Release: enables stay at their defaults so X/M captures the result.
            timeout_hit = !md_ready;
            state_nxt   = IDLE;
          end else begin
            pc_we      = 1'b0;
            fd_we      = 1'b0;
            dx_we      = 1'b0;
            xm_bubble  = 1'b1;
            md_cnt_nxt = md_cnt + CNT_W'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update
  // together from the values sampled at the edge.
  always_ff @(posedge clock) begin
    if (!ctrl_reset_n) begin
      state       <= IDLE;
      md_cnt      <= '0;
      md_timeout  <= 1'b0;
      stall_count <= '0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
      if (timeout_hit) begin
        md_timeout <= 1'b1;
      end
      if (!pc_we && (stall_count != '1)) begin
        stall_count <= stall_count + STALL_CNT_W'(1);
      end
    end
  end

  a_start_enters_busy : assert property (@(posedge clock) disable iff (!ctrl_reset_n)
    md_start |=> md_busy);
  a_no_start_in_busy : assert property (@(posedge clock) disable iff (!ctrl_reset_n)
    md_busy |-> !md_start);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: load-use, branch squash, mul/div release,
// timeout and mid-operation reset, with hand-computed expectations.
module tb_pipe_hazard_ctrl;

  localparam int unsigned MD_TIMEOUT  = 40;
  localparam int unsigned STALL_CNT_W = 16;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  logic clock = 1'b0;
  logic ctrl_reset_n;
  logic [4:0] fd_opcode, fd_rs, fd_rt, dx_opcode, dx_alu, dx_rd;
  logic branch_taken, md_ready;
  logic pc_we, fd_we, fd_flush, dx_we, dx_flush, xm_bubble, md_start, md_busy, md_timeout;
  logic [STALL_CNT_W-1:0] stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_hazard_ctrl #(.MD_TIMEOUT(MD_TIMEOUT), .STALL_CNT_W(STALL_CNT_W)) dut (
    .clock        (clock),
    .ctrl_reset_n (ctrl_reset_n),
    .fd_opcode    (fd_opcode),
    .fd_rs        (fd_rs),
    .fd_rt        (fd_rt),
    .dx_opcode    (dx_opcode),
    .dx_alu       (dx_alu),
    .dx_rd        (dx_rd),
    .branch_taken (branch_taken),
    .md_ready     (md_ready),
    .pc_we        (pc_we),
    .fd_we        (fd_we),
    .fd_flush     (fd_flush),
    .dx_we        (dx_we),
    .dx_flush     (dx_flush),
    .xm_bubble    (xm_bubble),
    .md_start     (md_start),
    .md_busy      (md_busy),
    .md_timeout   (md_timeout),
    .stall_count  (stall_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen 1 unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [4:0] fo, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] xo, input logic [4:0] xalu, input logic [4:0] xrd,
                       input logic br, input logic rdy);
    fd_opcode    = fo;
    fd_rs        = rs;
    fd_rt        = rt;
    dx_opcode    = xo;
    dx_alu       = xalu;
    dx_rd        = xrd;
    branch_taken = br;
    md_ready     = rdy;
    #1;
  endtask

  task automatic check_enables(input string tag, input logic pc, input logic fd, input logic dx);
    check({tag, ".pc_we"}, 32'(pc_we), 32'(pc));
    check({tag, ".fd_we"}, 32'(fd_we), 32'(fd));
    check({tag, ".dx_we"}, 32'(dx_we), 32'(dx));
  endtask

  initial begin
    ctrl_reset_n = 1'b0;
    drive(OP_ADD, 5'd0, 5'd0, OP_ADD, ALU_MUL, 5'd0, 1'b0, 1'b0);

    // Reset: X holds a mul, but nothing may start while reset is low.
    tick();
    check_enables("rst", 1'b0, 1'b0, 1'b0);
    check("rst.fd_flush", 32'(fd_flush), 1);
    check("rst.dx_flush", 32'(dx_flush), 1);
    check("rst.xm_bubble", 32'(xm_bubble), 0);
    check("rst.md_start", 32'(md_start), 0);
    check("rst.md_busy", 32'(md_busy), 0);
    check("rst.md_timeout", 32'(md_timeout), 0);
    check("rst.stall_count", 32'(stall_count), 0);

    ctrl_reset_n = 1'b1;
    drive(OP_ADD, 5'd0, 5'd0, OP_ADD, 5'd0, 5'd0, 1'b0, 1'b0);
    check_enables("idle", 1'b1, 1'b1, 1'b1);
    check("idle.dx_flush", 32'(dx_flush), 0);
    check("idle.fd_flush", 32'(fd_flush), 0);

    // Load-use on rs.
    drive(OP_ADD, 5'd5, 5'd0, OP_LW, 5'd0, 5'd5, 1'b0, 1'b0);
    check_enables("lu_rs", 1'b0, 1'b0, 1'b1);
    check("lu_rs.dx_flush", 32'(dx_flush), 1);
    tick();
    drive(OP_ADD, 5'd5, 5'd0, OP_ADD, 5'd0, 5'd0, 1'b0, 1'b0);
    check_enables("lu_after", 1'b1, 1'b1, 1'b1);
    check("lu_after.dx_flush", 32'(dx_flush), 0);
    check("lu_after.stall_count", 32'(stall_count), 1);

    // Load-use on rt of an R-type; addi does not read rt.
    drive(OP_ADD, 5'd1, 5'd7, OP_LW, 5'd0, 5'd7, 1'b0, 1'b0);
    check("lu_rt.pc_we", 32'(pc_we), 0);
    check("lu_rt.dx_flush", 32'(dx_flush), 1);
    tick();
    check("lu_rt.stall_count", 32'(stall_count), 2);
    drive(OP_ADDI, 5'd1, 5'd7, OP_LW, 5'd0, 5'd7, 1'b0, 1'b0);
    check("addi_rt.pc_we", 32'(pc_we), 1);

    // No false stalls: load to r0, and a jump that does not read rs.
    drive(OP_ADD, 5'd0, 5'd0, OP_LW, 5'd0, 5'd0, 1'b0, 1'b0);
    check("lw_r0.pc_we", 32'(pc_we), 1);
    check("lw_r0.dx_flush", 32'(dx_flush), 0);
    tick();
    drive(OP_J, 5'd3, 5'd0, OP_LW, 5'd0, 5'd3, 1'b0, 1'b0);
    check("lw_j.pc_we", 32'(pc_we), 1);
    check("lw_j.dx_flush", 32'(dx_flush), 0);
    tick();
    check("nostall.stall_count", 32'(stall_count), 2);

    // Branch beats a load-use hazard.
    drive(OP_ADD, 5'd5, 5'd0, OP_LW, 5'd0, 5'd5, 1'b1, 1'b0);
    check_enables("br_lu", 1'b1, 1'b1, 1'b1);
    check("br_lu.fd_flush", 32'(fd_flush), 1);
    check("br_lu.dx_flush", 32'(dx_flush), 1);
    tick();
    check("br_lu.stall_count", 32'(stall_count), 2);

    // Branch beats a mul in X: no start, remains IDLE.
    drive(OP_ADD, 5'd0, 5'd0, OP_ADD, ALU_MUL, 5'd4, 1'b1, 1'b0);
    check("br_md.md_start", 32'(md_start), 0);
    check("br_md.pc_we", 32'(pc_we), 1);
    tick();
    drive(OP_ADD, 5'd0, 5'd0, OP_ADD, 5'd0, 5'd0, 1'b0, 1'b0);
    check("br_md.md_busy", 32'(md_busy), 0);

    // mul, ready on the 4th BUSY cycle.
    drive(OP_ADD, 5'd0, 5'd0, OP_ADD, ALU_MUL, 5'd4, 1'b0, 1'b0);
    check("mul0.md_start", 32'(md_start), 1);
    check("mul0.xm_bubble", 32'(xm_bubble), 1);
    check("mul0.md_busy", 32'(md_busy), 0);
    check_enables("mul0", 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      // Branch and a load-use pattern in D are ignored while BUSY.
      drive(OP_ADD, 5'd4, 5'd4, OP_ADD, ALU_MUL, 5'd4, (k == 1), 1'b0);
      check($sformatf("mul%0d.md_busy", k), 32'(md_busy), 1);
      check($sformatf("mul%0d.md_start", k), 32'(md_start), 0);
      check($sformatf("mul%0d.xm_bubble", k), 32'(xm_bubble), 1);
      check($sformatf("mul%0d.fd_flush", k), 32'(fd_flush), 0);
      check($sformatf("mul%0d.pc_we", k), 32'(pc_we), 0);
    end
    tick();
    drive(OP_ADD, 5'd0, 5'd0, OP_ADD, ALU_MUL, 5'd4, 1'b0, 1'b1);
    check("mul4.md_busy", 32'(md_busy), 1);
    check("mul4.xm_bubble", 32'(xm_bubble), 0);
    check_enables("mul4", 1'b1, 1'b1, 1'b1);
    tick();
    check("mul.stall_count", 32'(stall_count), 6);

    // Back-to-back: a div right after the mul starts fresh; md_ready now held low.
    drive(OP_ADD, 5'd0, 5'd0, OP_ADD, ALU_DIV, 5'd9, 1'b0, 1'b0);
    check("div0.md_start", 32'(md_start), 1);
    check("div0.md_busy", 32'(md_busy), 0);
    for (int k = 1; k < int'(MD_TIMEOUT); k++) begin
      tick();
      check($sformatf("div%0d.pc_we", k), 32'(pc_we), 0);
      check($sformatf("div%0d.xm_bubble", k), 32'(xm_bubble), 1);
    end
    tick();
    check("div_to.md_busy", 32'(md_busy), 1);
    check("div_to.xm_bubble", 32'(xm_bubble), 0);
    check("div_to.md_timeout_pre", 32'(md_timeout), 0);
    check_enables("div_to", 1'b1, 1'b1, 1'b1);
    tick();
    drive(OP_ADD, 5'd0, 5'd0, OP_ADD, 5'd0, 5'd0, 1'b0, 1'b1);
    check("div_to.md_timeout", 32'(md_timeout), 1);
    check("div_to.md_busy_after", 32'(md_busy), 0);
    check("div_to.stall_count", 32'(stall_count), 46);
    check("idle_ready.pc_we", 32'(pc_we), 1);
    tick();
    tick();
    check("sticky.md_timeout", 32'(md_timeout), 1);
    check("sticky.stall_count", 32'(stall_count), 46);

    // Reset during the 2nd BUSY cycle aborts the mul.
    drive(OP_ADD, 5'd0, 5'd0, OP_ADD, ALU_MUL, 5'd2, 1'b0, 1'b0);
    check("rmul0.md_start", 32'(md_start), 1);
    tick();
    check("rmul1.md_busy", 32'(md_busy), 1);
    tick();
    check("rmul2.stall_count", 32'(stall_count), 48);
    ctrl_reset_n = 1'b0;
    #1;
    check("rmul_rst.pc_we", 32'(pc_we), 0);
    check("rmul_rst.fd_flush", 32'(fd_flush), 1);
    check("rmul_rst.dx_flush", 32'(dx_flush), 1);
    check("rmul_rst.md_busy", 32'(md_busy), 0);
    tick();
    ctrl_reset_n = 1'b1;
    drive(OP_ADD, 5'd0, 5'd0, OP_ADD, 5'd0, 5'd0, 1'b0, 1'b0);
    check("post_rst.md_busy", 32'(md_busy), 0);
    check("post_rst.stall_count", 32'(stall_count), 0);
    check("post_rst.md_timeout", 32'(md_timeout), 0);
    check("post_rst.pc_we", 32'(pc_we), 1);
    tick();
    check("post_rst.md_busy2", 32'(md_busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
